// File: rtl/sad_scheduler.sv
// Frame sequencer for the sad disparity engine: fetches each kernel column,
// hands it to sad when idle, and writes the returned depth to the depth buffer.
module sad_scheduler #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int KERNEL_WIDTH = 3,
    parameter int WARMUP       = 12,
    parameter int TIMEOUT      = 64
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    output logic                          rd_req_out,
    output logic [9:0]                    rd_h_out,
    output logic [8:0]                    rd_v_out,
    input  logic                          rd_valid_in,
    input  logic [KERNEL_WIDTH-1:0][7:0]  left_col_in,
    input  logic [KERNEL_WIDTH-1:0][7:0]  right_col_in,
    output logic [KERNEL_WIDTH-1:0][7:0]  sad_left_out,
    output logic [KERNEL_WIDTH-1:0][7:0]  sad_right_out,
    output logic [10:0]                   sad_hcount_out,
    output logic [9:0]                    sad_vcount_out,
    output logic                          sad_valid_out,
    input  logic                          sad_busy_in,
    input  logic                          sad_valid_in,
    input  logic [7:0]                    sad_depth_in,
    output logic                          wr_en_out,
    output logic [16:0]                   wr_addr_out,
    output logic [7:0]                    wr_data_out,
    output logic                          busy_out,
    output logic                          frame_done_out,
    output logic                          timeout_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [9:0]      H_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]      V_LAST   = 9'(V_ACTIVE - KERNEL_WIDTH);
    localparam logic [9:0]      WARMUP_H = 10'(WARMUP);
    localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);

    state_t                        state, state_next;
    logic [9:0]                    h;
    logic [8:0]                    v;
    logic [TW-1:0]                 tcnt;
    logic [KERNEL_WIDTH-1:0][7:0]  left_q, right_q;
    logic                          timed_out;
    logic                          last_col;

    always_comb begin
        state_next = state;
        timed_out  = 1'b0;
        last_col   = (h == H_LAST) && (v == V_LAST);
        case (state)
            S_IDLE:  if (start_in) state_next = S_FETCH;
            S_FETCH: if (rd_valid_in) state_next = S_ISSUE;
            S_ISSUE: if (!sad_busy_in) state_next = S_WAIT;
            S_WAIT: begin
                if (sad_valid_in) begin
                    state_next = S_WRITE;
                end else if (tcnt == T_LAST) begin
                    timed_out  = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: state_next = last_col ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are registered on the transition edge so they land in the first cycle of the new state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= S_IDLE;
            h              <= '0;
            v              <= '0;
            tcnt           <= '0;
            left_q         <= '0;
            right_q        <= '0;
            rd_req_out     <= 1'b0;
            sad_left_out   <= '0;
            sad_right_out  <= '0;
            sad_hcount_out <= '0;
            sad_vcount_out <= '0;
            sad_valid_out  <= 1'b0;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            frame_done_out <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            state          <= state_next;
            rd_req_out     <= (state_next == S_FETCH) && (state != S_FETCH);
            sad_valid_out  <= (state == S_ISSUE) && (state_next == S_WAIT);
            wr_en_out      <= (state == S_WAIT) && (state_next == S_WRITE);
            frame_done_out <= (state == S_WRITE) && (state_next == S_DONE);

            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        h           <= '0;
                        v           <= '0;
                        timeout_out <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (rd_valid_in) begin
                        left_q  <= left_col_in;
                        right_q <= right_col_in;
                    end
                end
                S_ISSUE: begin
                    if (!sad_busy_in) begin
                        sad_left_out   <= left_q;
                        sad_right_out  <= right_q;
                        sad_hcount_out <= 11'(h);
                        sad_vcount_out <= 10'(v);
                        tcnt           <= '0;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (state_next == S_WRITE) begin
                        wr_addr_out <= 17'(v) * 17'(H_ACTIVE) + 17'(h);
                        // Warmup columns are still fed to sad but their result is discarded.
                        if (h < WARMUP_H || timed_out) begin
                            wr_data_out <= '0;
                        end else begin
                            wr_data_out <= sad_depth_in;
                        end
                        if (timed_out) timeout_out <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (h == H_LAST) begin
                        h <= '0;
                        v <= v + 1'b1;
                    end else begin
                        h <= h + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_out = (state != S_IDLE);
        rd_h_out = h;
        rd_v_out = v;
    end

endmodule

// File: tb/tb_sad_scheduler.sv
// Directed bench for sad_scheduler on a 16x4 frame with a behavioural sad responder.
module tb_sad_scheduler;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start_in;
    logic             rd_req_out;
    logic [9:0]       rd_h_out;
    logic [8:0]       rd_v_out;
    logic             rd_valid_in;
    logic [2:0][7:0]  left_col_in;
    logic [2:0][7:0]  right_col_in;
    logic [2:0][7:0]  sad_left_out;
    logic [2:0][7:0]  sad_right_out;
    logic [10:0]      sad_hcount_out;
    logic [9:0]       sad_vcount_out;
    logic             sad_valid_out;
    logic             sad_busy_in;
    logic             sad_valid_in;
    logic [7:0]       sad_depth_in;
    logic             wr_en_out;
    logic [16:0]      wr_addr_out;
    logic [7:0]       wr_data_out;
    logic             busy_out;
    logic             frame_done_out;
    logic             timeout_out;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int done_count = 0;
    bit to_exp = 1'b0;

    always #5 clk_in = ~clk_in;

    sad_scheduler #(
        .H_ACTIVE(16),
        .V_ACTIVE(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .start_in(start_in),
        .rd_req_out(rd_req_out),
        .rd_h_out(rd_h_out),
        .rd_v_out(rd_v_out),
        .rd_valid_in(rd_valid_in),
        .left_col_in(left_col_in),
        .right_col_in(right_col_in),
        .sad_left_out(sad_left_out),
        .sad_right_out(sad_right_out),
        .sad_hcount_out(sad_hcount_out),
        .sad_vcount_out(sad_vcount_out),
        .sad_valid_out(sad_valid_out),
        .sad_busy_in(sad_busy_in),
        .sad_valid_in(sad_valid_in),
        .sad_depth_in(sad_depth_in),
        .wr_en_out(wr_en_out),
        .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out),
        .busy_out(busy_out),
        .frame_done_out(frame_done_out),
        .timeout_out(timeout_out)
    );

    always @(negedge clk_in) begin
        if (wr_en_out) wr_count++;
        if (frame_done_out) done_count++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_l(input int h, input int row);
        return 8'(row * 16 + h);
    endfunction

    function automatic logic [7:0] pix_r(input int h, input int row);
        return 8'((row * 16 + h) ^ 8'hA5);
    endfunction

    task automatic start_frame();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("start_busy", busy_out, 1);
        check("start_timeout_clr", timeout_out, 0);
    endtask

    task automatic do_col(input int h, input int v, input int lat, input int busy_cyc,
                          input bit drop, input bit spur);
        int n;
        int early;
        n = 0;
        while (!rd_req_out && n < 20) begin
            tick();
            n++;
        end
        check("rd_req", rd_req_out, 1);
        check("rd_addr", {rd_v_out, rd_h_out}, {9'(v), 10'(h)});
        repeat (lat) begin
            if (spur) begin
                sad_valid_in = 1'b1;
                sad_depth_in = 8'hAA;
                start_in     = 1'b1;
            end
            tick();
            sad_valid_in = 1'b0;
            start_in     = 1'b0;
            check("rd_req_single", rd_req_out, 0);
        end
        for (int r = 0; r < 3; r++) begin
            left_col_in[r]  = pix_l(h, v + r);
            right_col_in[r] = pix_r(h, v + r);
        end
        rd_valid_in = 1'b1;
        sad_busy_in = (busy_cyc > 0);
        tick();
        rd_valid_in  = 1'b0;
        left_col_in  = {3{8'hEE}};
        right_col_in = {3{8'hEE}};
        early = 0;
        repeat (busy_cyc) begin
            if (sad_valid_out) early++;
            tick();
        end
        sad_busy_in = 1'b0;
        if (sad_valid_out) early++;
        tick();
        check("strobe_while_busy", early, 0);
        check("strobe", sad_valid_out, 1);
        check("sad_left", sad_left_out, {pix_l(h, v + 2), pix_l(h, v + 1), pix_l(h, v)});
        check("sad_right", sad_right_out, {pix_r(h, v + 2), pix_r(h, v + 1), pix_r(h, v)});
        check("sad_coord", {sad_vcount_out, sad_hcount_out}, {10'(v), 11'(h)});
        tick();
        check("strobe_once", sad_valid_out, 0);
        if (!drop) begin
            sad_valid_in = 1'b1;
            sad_depth_in = 8'(h);
            tick();
            sad_valid_in = 1'b0;
        end else begin
            n = 1;
            while (!wr_en_out && n < 100) begin
                tick();
                n++;
            end
            check("timeout_cycles", n, 64);
            to_exp = 1'b1;
        end
        check("wr_en", wr_en_out, 1);
        check("wr_addr", wr_addr_out, 32'(v * 16 + h));
        check("wr_data", wr_data_out, (drop || h < 12) ? 32'd0 : 32'(h));
        check("timeout_flag", timeout_out, to_exp);
        check("coord_held", {sad_vcount_out, sad_hcount_out}, {10'(v), 11'(h)});
    endtask

    task automatic run_frame(input int drop_h, input int spur_h, input int busy_h);
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 16; h++) begin
                do_col(h, v, int'($urandom_range(1, 5)),
                       (v == 0 && h == busy_h) ? 20 : 0,
                       (v == 1 && h == drop_h),
                       (v == 0 && h == spur_h));
            end
        end
        tick();
        check("frame_done", frame_done_out, 1);
        check("busy_at_done", busy_out, 1);
        tick();
        check("frame_done_pulse", frame_done_out, 0);
        check("idle_after_done", busy_out, 0);
    endtask

    initial begin
        rst_in       = 1'b1;
        start_in     = 1'b0;
        rd_valid_in  = 1'b0;
        left_col_in  = '0;
        right_col_in = '0;
        sad_busy_in  = 1'b0;
        sad_valid_in = 1'b0;
        sad_depth_in = '0;
        repeat (3) tick();
        check("rst_ctrl", {rd_req_out, sad_valid_out, wr_en_out, busy_out, frame_done_out, timeout_out}, 0);
        check("rst_rd_addr", {rd_v_out, rd_h_out}, 0);
        check("rst_sad_cols", {sad_left_out, sad_right_out}, 0);
        check("rst_wr_bus", {wr_addr_out, wr_data_out}, 0);
        rst_in = 1'b0;
        tick();

        // Reset while waiting for a sad result.
        start_frame();
        tick();
        left_col_in[0]  = pix_l(0, 0);
        left_col_in[1]  = pix_l(0, 1);
        left_col_in[2]  = pix_l(0, 2);
        right_col_in[0] = pix_r(0, 0);
        right_col_in[1] = pix_r(0, 1);
        right_col_in[2] = pix_r(0, 2);
        rd_valid_in = 1'b1;
        tick();
        rd_valid_in = 1'b0;
        tick();
        check("pre_rst_strobe", sad_valid_out, 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("midrst_ctrl", {rd_req_out, sad_valid_out, wr_en_out, busy_out, frame_done_out, timeout_out}, 0);
        check("midrst_sad_cols", {sad_left_out, sad_right_out}, 0);
        check("midrst_coord", {sad_vcount_out, sad_hcount_out}, 0);
        sad_valid_in = 1'b1;
        sad_depth_in = 8'h55;
        tick();
        sad_valid_in = 1'b0;
        repeat (3) tick();
        check("midrst_no_write", wr_count, 0);
        check("midrst_idle", busy_out, 0);

        // Full frame: busy stall, dropped result, spurious start/result.
        to_exp = 1'b0;
        start_frame();
        run_frame(13, 5, 2);
        check("frame1_writes", wr_count, 32);
        check("frame1_done_count", done_count, 1);
        check("frame1_timeout_sticky", timeout_out, 1);

        // Next frame clears the sticky flag.
        to_exp = 1'b0;
        start_frame();
        run_frame(-1, -1, -1);
        check("frame2_writes", wr_count, 64);
        check("frame2_done_count", done_count, 2);
        check("frame2_timeout", timeout_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
